lane_access_ctrl: RTL and testbench

- Controller for a single-lane, bidirectional parking gate shared by entering and exiting cars.
- Arbitrates entrance and exit requests round-robin and sequences the gate open/pass/close cycle with a no-show timeout.
- Owns the authoritative occupancy count and the full/empty flags consumed by the display datapath.
- Sits between the synchronized GPIO sensors and the gate LEDs/HEX datapath.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/lane_timer.sv | 26 ++
 rtl/lane_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_lane_access_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking lane gate controller.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OPEN_IN  = 3'd1,
        PASS_IN  = 3'd2,
        OPEN_OUT = 3'd3,
        PASS_OUT = 3'd4,
        CLOSE    = 3'd5
    } state_t;

    typedef enum logic {
        ENTRY = 1'b0,
        EXIT  = 1'b1
    } dir_t;

    localparam int DEFAULT_CAPACITY = 3;

endpackage

// File: rtl/lane_timer.sv
// Loadable down-counter shared by the gate-open timeout and the post-close hold.
module lane_timer #(
    parameter int TMR_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic [TMR_W-1:0] value,
    output logic             zero
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - TMR_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/lane_access_ctrl.sv
// Single-lane bidirectional gate controller: round-robin entry/exit arbitration,
// open/pass/close sequencing with no-show timeout, and the occupancy count.
module lane_access_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = DEFAULT_CAPACITY,
    parameter int TIMEOUT_CYC = 8,
    parameter int HOLD_CYC    = 2,
    parameter int TMR_W       = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       arrive,
    input  logic       depart,
    input  logic       beam,
    output logic       open_in,
    output logic       open_out,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       done_in,
    output logic       done_out,
    output logic       abort
);

    state_t           state, state_nx;
    dir_t             last_dir, last_dir_nx;
    logic             tmr_load, tmr_dec, tmr_zero, tmr_last;
    logic [TMR_W-1:0] tmr_val, tmr_value;
    logic             fin_in, fin_out, tmo;
    logic             fin_in_nx, fin_out_nx, tmo_nx;
    logic             ent_ok, ext_ok;
    logic [3:0]       cnt_nx;

    function automatic logic [3:0] sat_count(input logic [3:0] c, input logic inc,
                                             input logic dn);
        logic [3:0] r;
        r = c;
        if (inc && !dn && (c < 4'(CAPACITY))) r = c + 4'd1;
        else if (dn && !inc && (c != 4'd0))   r = c - 4'd1;
        return r;
    endfunction

    lane_timer #(.TMR_W(TMR_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .value    (tmr_value),
        .zero     (tmr_zero)
    );

    // Leave OPEN/CLOSE on the edge where the timer reaches zero, not one later.
    assign tmr_last = tmr_zero || (tmr_value == TMR_W'(1));
    assign ent_ok   = arrive & ~full;
    assign ext_ok   = depart & ~empty;
    assign cnt_nx   = sat_count(count, fin_in, fin_out);

    always_comb begin
        state_nx    = state;
        last_dir_nx = last_dir;
        tmr_load    = 1'b0;
        tmr_val     = TMR_W'(TIMEOUT_CYC);
        tmr_dec     = 1'b0;
        fin_in_nx   = 1'b0;
        fin_out_nx  = 1'b0;
        tmo_nx      = 1'b0;
        case (state)
            IDLE: begin
                if (ent_ok && ext_ok) begin
                    tmr_load = 1'b1;
                    if (last_dir == EXIT) begin
                        state_nx    = OPEN_IN;
                        last_dir_nx = ENTRY;
                    end else begin
                        state_nx    = OPEN_OUT;
                        last_dir_nx = EXIT;
                    end
                end else if (ent_ok) begin
                    tmr_load = 1'b1;
                    state_nx = OPEN_IN;
                end else if (ext_ok) begin
                    tmr_load = 1'b1;
                    state_nx = OPEN_OUT;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                if (beam) begin
                    state_nx = (state == OPEN_IN) ? PASS_IN : PASS_OUT;
                end else if (tmr_last) begin
                    state_nx = CLOSE;
                    tmo_nx   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PASS_IN, PASS_OUT: begin
                // No timeout here: a car standing in the beam keeps the gate open.
                if (!beam) begin
                    state_nx   = CLOSE;
                    fin_in_nx  = (state == PASS_IN);
                    fin_out_nx = (state == PASS_OUT);
                    tmr_load   = 1'b1;
                    tmr_val    = TMR_W'(HOLD_CYC);
                end
            end
            CLOSE: begin
                if (tmr_last) state_nx = IDLE;
                else          tmr_dec  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs trail the state by one edge so count, done and gate close together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last_dir <= EXIT;
            fin_in   <= 1'b0;
            fin_out  <= 1'b0;
            tmo      <= 1'b0;
            open_in  <= 1'b0;
            open_out <= 1'b0;
            count    <= 4'd0;
            full     <= 1'b0;
            empty    <= 1'b1;
            busy     <= 1'b0;
            done_in  <= 1'b0;
            done_out <= 1'b0;
            abort    <= 1'b0;
        end else begin
            state    <= state_nx;
            last_dir <= last_dir_nx;
            fin_in   <= fin_in_nx;
            fin_out  <= fin_out_nx;
            tmo      <= tmo_nx;
            open_in  <= (state == OPEN_IN)  || (state == PASS_IN);
            open_out <= (state == OPEN_OUT) || (state == PASS_OUT);
            count    <= cnt_nx;
            full     <= (cnt_nx == 4'(CAPACITY));
            empty    <= (cnt_nx == 4'd0);
            busy     <= (state != IDLE);
            done_in  <= fin_in;
            done_out <= fin_out;
            abort    <= tmo;
        end
    end

endmodule

// File: tb/tb_lane_access_ctrl.sv
// Scoreboard bench: expected completion events are queued as cars are driven
// through the gate and compared whenever the controller pulses done/abort.
module tb_lane_access_ctrl;

    logic       clock, reset, arrive, depart, beam;
    logic       open_in, open_out, full, empty, busy, done_in, done_out, abort;
    logic [3:0] count;

    typedef struct {
        logic [2:0] ev;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   overlap = 0;

    lane_access_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .arrive   (arrive),
        .depart   (depart),
        .beam     (beam),
        .open_in  (open_in),
        .open_out (open_out),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .done_in  (done_in),
        .done_out (done_out),
        .abort    (abort)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (open_in && open_out) overlap++;
            if (done_in || done_out || abort) begin
                if (exp_q.size() == 0) begin
                    check("ev_unexpected", int'({done_in, done_out, abort}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_kind", int'({done_in, done_out, abort}), int'(mon_e.ev));
                    check("ev_count", int'(count), mon_e.cnt);
                end
            end
        end
    end

    task automatic wait_open();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (open_in || open_out) return;
        end
        check("open_timeout", int'(open_in | open_out), 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (!busy) return;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic pass_car();
        beam = 1'b1;
        repeat (2) @(negedge clock);
        beam = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (!open_in && !open_out) return;
        end
        check("close_timeout", int'(open_in | open_out), 0);
    endtask

    task automatic push(input logic [2:0] ev, input int cnt);
        exp_t e;
        e.ev  = ev;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        int   n;
        logic seen;
        int   tie_cnt[3];
        tie_cnt = '{2, 1, 2};

        reset = 1'b0; arrive = 1'b0; depart = 1'b0; beam = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", int'({open_in, open_out, count, full, empty, busy,
                                     done_in, done_out, abort}), 12'h010);
        reset = 1'b1;
        @(negedge clock);

        // Basic entry with grant-to-open latency
        arrive = 1'b1;
        @(posedge clock); #1;
        arrive = 1'b0;
        @(negedge clock);
        check("open_latency_early", int'(open_in), 0);
        @(negedge clock);
        check("open_latency", int'(open_in), 1);
        check("busy_open", int'(busy), 1);
        push(3'b100, 1);
        pass_car();
        wait_idle();
        check("entry_count", int'(count), 1);
        check("entry_not_empty", int'(empty), 0);

        // Spurious beam while idle
        beam = 1'b1;
        repeat (3) @(negedge clock);
        beam = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_beam_count", int'(count), 1);
        check("idle_beam_busy", int'(busy), 0);

        // Tie arbitration: entry, exit, entry
        arrive = 1'b1; depart = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_open();
            check("tie_dir", int'({open_in, open_out}), (i == 1) ? 1 : 2);
            if (i == 2) begin arrive = 1'b0; depart = 1'b0; end
            push((i == 1) ? 3'b010 : 3'b100, tie_cnt[i]);
            pass_car();
        end
        wait_idle();
        check("tie_count", int'(count), 2);

        // Fill to capacity
        arrive = 1'b1;
        wait_open();
        arrive = 1'b0;
        push(3'b100, 3);
        pass_car();
        wait_idle();
        check("full_count", int'(count), 3);
        check("full_flag", int'(full), 1);
        arrive = 1'b1; seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            seen |= busy | open_in;
        end
        arrive = 1'b0;
        check("full_no_grant", int'(seen), 0);

        // Drain to empty
        for (int i = 0; i < 3; i++) begin
            depart = 1'b1;
            wait_open();
            check("exit_gate", int'({open_in, open_out}), 1);
            depart = 1'b0;
            push(3'b010, 2 - i);
            pass_car();
            wait_idle();
        end
        check("empty_flag", int'(empty), 1);
        depart = 1'b1; seen = 1'b0;
        repeat (10) begin
            @(negedge clock);
            seen |= busy | open_out;
        end
        depart = 1'b0;
        check("empty_no_grant", int'(seen), 0);
        check("empty_hold", int'({empty, count}), 16);

        // No-show timeout
        arrive = 1'b1;
        wait_open();
        arrive = 1'b0;
        push(3'b001, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            n++;
            if (abort) break;
        end
        check("timeout_cycles", n, 8);
        check("timeout_gate_closed", int'(open_in), 0);
        wait_idle();
        check("timeout_count", int'(count), 0);

        // Spurious beam during CLOSE
        arrive = 1'b1;
        wait_open();
        arrive = 1'b0;
        push(3'b100, 1);
        pass_car();
        beam = 1'b1;
        @(negedge clock);
        beam = 1'b0;
        wait_idle();
        repeat (2) @(negedge clock);
        check("close_beam_count", int'(count), 1);

        // Asynchronous reset during PASS_IN
        arrive = 1'b1;
        wait_open();
        arrive = 1'b0;
        beam = 1'b1;
        repeat (2) @(negedge clock);
        check("pre_reset_open", int'(open_in), 1);
        reset = 1'b0;
        #1;
        check("async_reset", int'({open_in, count}), 0);
        beam = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_reset_idle", int'({busy, open_in, open_out, count}), 0);
        arrive = 1'b1;
        wait_open();
        check("post_reset_grant", int'(open_in), 1);
        arrive = 1'b0;
        push(3'b100, 1);
        pass_car();
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        check("gate_exclusion", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
